// File: rtl/data_mem_ctrl.sv
// Bus initiator for the 8-bit data RAM: single-byte and burst loads/stores
// over a shared tristate bus with write-beat handshake and read-beat strobe.
module data_mem_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] base_addr,
  input  logic [3:0] len,
  output logic       busy,
  output logic       done,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       mem_w,
  output logic       mem_r,
  output logic [7:0] mem_addr,
  inout  wire  [7:0] mem_d
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and burst bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and bus-strobe logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    mem_w    = 1'b0;
    mem_r    = 1'b0;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = base_addr;
          cnt_d   = len;
          state_d = we ? WR : RD;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_w  = 1'b1;
          addr_d = addr_q + AW'(1);
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      RD: begin
        mem_r  = 1'b1;
        addr_d = addr_q + AW'(1);
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mem_addr = addr_q;
  assign mem_d    = mem_w ? wr_data : {DW{1'bz}};

  // Read beat capture; the RAM presents data combinationally during RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state_q == RD);
      if (state_q == RD) rd_data <= mem_d;
    end
  end

endmodule
